// File: rtl/ISO14443A_pkg.sv
// ISO/IEC 14443-3A framing helpers shared by the transmit and receive framers.
package ISO14443A_pkg;

  // Start-of-communication bit that opens every PICC frame.
  localparam logic SOC_BIT = 1'b1;

  // One byte queued for transmission together with its framing attributes.
  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [2:0] bits;
  } tx_byte_t;

  // Odd parity: the returned bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

  // A last byte with a non-zero bit count is sent without parity.
  function automatic logic is_partial(input tx_byte_t b);
    return b.last && (b.bits != 3'd0);
  endfunction

  // Number of data bits to send for a byte (8, or the partial count).
  function automatic logic [3:0] bit_count(input tx_byte_t b);
    return is_partial(b) ? {1'b0, b.bits} : 4'd8;
  endfunction

endpackage

// File: rtl/frame_encode.sv
// Transmit-side 14443-3A framer: byte stream in, SOC + LSB-first data + odd
// parity out, one bit per downstream out_req pulse.
module frame_encode
  import ISO14443A_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic [2:0] in_bits,
  input  logic       out_req,
  output logic       out_valid,
  output logic       out_data,
  output logic       out_last,
  output logic       underrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_SOC, ST_DATA, ST_PARITY} state_t;

  state_t     r_state;
  tx_byte_t   r_buf;
  logic       r_buf_full;
  // Set for one cycle when an idle start took its byte straight from the
  // inputs; the buffered copy is then already consumed and is dropped.
  logic       r_buf_spent;
  logic [7:0] r_shift;
  logic [3:0] r_cnt;
  logic [3:0] r_nbits;
  logic       r_last;
  logic       r_partial;
  logic       r_par;
  logic       r_out_valid;
  logic       r_out_data;
  logic       r_out_last;
  logic       r_underrun;

  tx_byte_t   w_in;
  tx_byte_t   w_src;
  logic       w_hs;
  logic       w_drain;
  logic       w_src_partial;
  logic [3:0] w_src_nbits;

  assign in_ready  = ~r_buf_full;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign underrun  = r_underrun;

  // Handshake, buffer drain and the byte source for the next shift load.
  always_comb begin
    w_in          = '{data: in_data, last: in_last, bits: in_bits};
    w_hs          = in_valid && !r_buf_full;
    w_drain       = r_buf_spent
                 || ((r_state == ST_IDLE) && r_buf_full)
                 || ((r_state == ST_PARITY) && out_req && !r_last && r_buf_full);
    // While idle with an empty buffer the incoming byte bypasses the buffer
    // so the SOC bit appears in the cycle after the handshake.
    w_src         = r_buf_full ? r_buf : w_in;
    w_src_partial = is_partial(w_src);
    w_src_nbits   = bit_count(w_src);
  end

  // One-byte input buffer: fills on handshake, empties on shift load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_buf_spent <= 1'b0;
    end else begin
      r_buf_spent <= (r_state == ST_IDLE) && w_hs;
      if (w_hs) begin
        r_buf      <= w_in;
        r_buf_full <= 1'b1;
      end else if (w_drain) begin
        r_buf_full <= 1'b0;
      end
    end
  end

  // Framing FSM with registered bit outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_nbits     <= '0;
      r_last      <= 1'b0;
      r_partial   <= 1'b0;
      r_par       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 1'b0;
      r_out_last  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_buf_full || w_hs) begin
            r_state     <= ST_SOC;
            r_shift     <= w_src.data;
            r_cnt       <= '0;
            r_last      <= w_src.last;
            r_partial   <= w_src_partial;
            r_nbits     <= w_src_nbits;
            r_par       <= odd_parity(w_src.data);
            r_out_valid <= 1'b1;
            r_out_data  <= SOC_BIT;
            r_out_last  <= 1'b0;
          end
        end
        ST_SOC: begin
          if (out_req) begin
            r_state    <= ST_DATA;
            r_out_data <= r_shift[0];
            r_out_last <= r_partial && (r_nbits == 4'd1);
          end
        end
        ST_DATA: begin
          if (out_req) begin
            if (r_cnt == r_nbits - 4'd1) begin
              if (r_partial) begin
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b0;
                r_out_data  <= 1'b0;
                r_out_last  <= 1'b0;
              end else begin
                r_state    <= ST_PARITY;
                r_out_data <= r_par;
                r_out_last <= r_last;
              end
            end else begin
              r_cnt      <= r_cnt + 4'd1;
              r_shift    <= {1'b0, r_shift[7:1]};
              r_out_data <= r_shift[1];
              r_out_last <= r_partial && (r_cnt + 4'd2 == r_nbits);
            end
          end
        end
        ST_PARITY: begin
          if (out_req) begin
            if (!r_last && r_buf_full) begin
              // Next byte follows directly, no SOC between bytes.
              r_state    <= ST_DATA;
              r_shift    <= w_src.data;
              r_cnt      <= '0;
              r_last     <= w_src.last;
              r_partial  <= w_src_partial;
              r_nbits    <= w_src_nbits;
              r_par      <= odd_parity(w_src.data);
              r_out_data <= w_src.data[0];
              r_out_last <= w_src_partial && (w_src_nbits == 4'd1);
            end else begin
              // Normal end after a last byte, or abort when the next byte
              // has not arrived in time.
              r_underrun  <= !r_last;
              r_state     <= ST_IDLE;
              r_out_valid <= 1'b0;
              r_out_data  <= 1'b0;
              r_out_last  <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_encode.sv
// Self-checking bench for frame_encode: directed framing cases plus random
// frames compared against a bit-list reference model.
module tb_frame_encode;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic [2:0] in_bits = '0;
  logic       out_req = 1'b0;
  logic       out_valid;
  logic       out_data;
  logic       out_last;
  logic       underrun;

  int n_checks = 0;
  int n_errors = 0;

  // Frame description used by the reference model.
  logic [7:0] fr_data[$];
  logic [2:0] fr_tail;

  bit exp_bits[$];
  bit exp_last[$];
  bit got_bits[$];
  bit got_last[$];
  bit got_und;

  frame_encode dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bits   (in_bits),
    .out_req   (out_req),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected on-air bit list: SOC, LSB-first data, odd parity after full bytes.
  function automatic void build_expected(input bit frame_ends);
    int n;
    int ones;
    exp_bits.delete();
    exp_last.delete();
    exp_bits.push_back(1'b1);
    exp_last.push_back(1'b0);
    for (int i = 0; i < fr_data.size(); i++) begin
      n = 8;
      if (frame_ends && i == fr_data.size() - 1 && fr_tail != 3'd0) n = int'(fr_tail);
      ones = 0;
      for (int k = 0; k < n; k++) begin
        exp_bits.push_back(fr_data[i][k]);
        exp_last.push_back(1'b0);
        ones += int'(fr_data[i][k]);
      end
      if (n == 8) begin
        exp_bits.push_back((ones % 2) == 0);
        exp_last.push_back(1'b0);
      end
    end
    if (frame_ends) exp_last[exp_last.size() - 1] = 1'b1;
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic l, input logic [2:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_bits  = b;
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_eq("push_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Consume bits with random out_req spacing until out_valid drops.
  task automatic collect(input int gap_max);
    int guard;
    got_bits.delete();
    got_last.delete();
    got_und = 1'b0;
    guard = 0;
    while (!out_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      check_eq("start_timeout", 32'(out_valid), 32'd1);
    end else begin
      guard = 0;
      while (out_valid && guard < 5000) begin
        got_bits.push_back(out_data);
        got_last.push_back(out_last);
        repeat ($urandom_range(gap_max - 1, 0)) @(negedge clk);
        out_req = 1'b1;
        @(negedge clk);
        out_req = 1'b0;
        guard++;
        if (underrun) begin
          got_und = 1'b1;
          check_eq("und_valid_low", 32'(out_valid), 32'd0);
        end
      end
      if (out_valid) check_eq("frame_timeout", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic compare_frame(input string tag);
    check_eq({tag, "_len"}, 32'(got_bits.size()), 32'(exp_bits.size()));
    for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++) begin
      check_eq($sformatf("%s_bit%0d", tag, i), 32'(got_bits[i]), 32'(exp_bits[i]));
      check_eq($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(exp_last[i]));
    end
  endtask

  task automatic run_frame(input string tag, input int gap_max);
    fork
      begin
        for (int i = 0; i < fr_data.size(); i++) begin
          if (i == fr_data.size() - 1) push_byte(fr_data[i], 1'b1, fr_tail);
          else push_byte(fr_data[i], 1'b0, 3'($urandom_range(7, 0)));
        end
      end
      collect(gap_max);
    join
    build_expected(1'b1);
    compare_frame(tag);
    check_eq({tag, "_und"}, 32'(got_und), 32'd0);
    $display("frame %s bytes=%0d bits=%0d", tag, fr_data.size(), got_bits.size());
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_valid", 32'(out_valid), 32'd0);
    check_eq("idle_data", 32'(out_data), 32'd0);
    check_eq("idle_last", 32'(out_last), 32'd0);
    check_eq("idle_und", 32'(underrun), 32'd0);
    check_eq("idle_ready", 32'(in_ready), 32'd1);

    // 0x01 full last byte, with start-latency checks.
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1; in_bits = 3'd0;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("lat_valid", 32'(out_valid), 32'd1);
    check_eq("lat_soc", 32'(out_data), 32'd1);
    check_eq("lat_ready_lo", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_eq("lat_ready_hi", 32'(in_ready), 32'd1);
    collect(1);
    fr_data = '{8'h01}; fr_tail = 3'd0;
    build_expected(1'b1);
    compare_frame("b01");
    $display("frame b01 bits=%0d", got_bits.size());

    // 0x00 full last byte: parity 1.
    fr_data = '{8'h00}; fr_tail = 3'd0;
    run_frame("b00", 2);

    // 0x05 partial last byte for every bit count.
    for (int b = 1; b < 8; b++) begin
      fr_data = '{8'h05}; fr_tail = 3'(b);
      run_frame($sformatf("p05_%0d", b), 1);
    end

    // Three-byte frame with random spacing.
    fr_data = '{8'hA5, 8'h3C, 8'hFF}; fr_tail = 3'd0;
    run_frame("b3", 20);

    // Underrun: second byte withheld past the first parity bit.
    fr_data = '{8'hC3}; fr_tail = 3'd0;
    push_byte(8'hC3, 1'b0, 3'd0);
    collect(3);
    build_expected(1'b0);
    compare_frame("urun");
    check_eq("urun_und", 32'(got_und), 32'd1);
    $display("frame urun bits=%0d und=%0d", got_bits.size(), got_und);
    fr_data = '{8'h5A}; fr_tail = 3'd0;
    push_byte(8'h5A, 1'b1, 3'd0);
    collect(2);
    build_expected(1'b1);
    compare_frame("late");
    check_eq("late_und", 32'(got_und), 32'd0);
    $display("frame late bits=%0d", got_bits.size());

    // Reset mid-DATA with a byte buffered.
    push_byte(8'h96, 1'b0, 3'd0);
    push_byte(8'h11, 1'b1, 3'd0);
    repeat (3) begin
      out_req = 1'b1;
      @(negedge clk);
      out_req = 1'b0;
      @(negedge clk);
    end
    check_eq("mid_valid", 32'(out_valid), 32'd1);
    check_eq("mid_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_data", 32'(out_data), 32'd0);
    check_eq("arst_last", 32'(out_last), 32'd0);
    check_eq("arst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("post_valid", 32'(out_valid), 32'd0);
    check_eq("post_ready", 32'(in_ready), 32'd1);
    fr_data = '{8'h6B, 8'h80}; fr_tail = 3'd0;
    run_frame("post", 4);

    // Random frames.
    for (int f = 0; f < 10; f++) begin
      fr_data.delete();
      repeat ($urandom_range(4, 1)) fr_data.push_back(8'($urandom_range(255, 0)));
      fr_tail = 3'($urandom_range(7, 0));
      run_frame($sformatf("rnd%0d", f), $urandom_range(20, 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_encode.md
# frame_encode

Transmit-side ISO/IEC 14443-3A framing block for the PICC: accepts the response as a byte stream and serialises it LSB first. It prepends the SOC bit and inserts an odd parity bit after every complete byte, omitting parity after a partial final byte. It sits between the PICC protocol layer and the bit-level Manchester/subcarrier encoder, which pulls one bit per bit period. It is the counterpart of frame_decode on the receive path.

## Interface
- No parameters.
- clk  input  1  13.56 MHz system clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_last/in_bits hold a byte to send.
- in_ready  output  1  byte buffer empty; the byte transfers on in_valid && in_ready.
- in_data  input  8  byte to transmit, sent LSB first.
- in_last  input  1  this byte ends the frame.
- in_bits  input  3  valid bits in a last byte (1–7 = partial; 0 = full 8). Ignored unless in_last.
- out_req  input  1  1-cycle pulse from the bit encoder: current bit consumed, present the next.
- out_valid  output  1  frame in progress; out_data is meaningful.
- out_data  output  1  current bit.
- out_last  output  1  current bit is the final bit of the frame.
- underrun  output  1  1-cycle pulse: next byte not buffered when needed; frame aborted.

## Operation
- One-byte buffer holds {data, last, bits}.
  - in_ready = !buf_full.
  - The buffer fills on a handshake and empties when the byte is loaded into the shift register.
- FSM states: IDLE, SOC, DATA, PARITY.
- IDLE → SOC when buf_full.
  - On that transition the buffer is loaded into the shift register, the bit counter is cleared and the parity accumulator is cleared.
  - out_valid = 1, out_data = 1 (SOC bit).
- SOC → DATA on out_req. out_data = shift[0].
- DATA, on each out_req:
  - The shift register shifts right, the counter increments and parity ^= the sent bit.
  - Bit count for a byte is 8, or in_bits when last and in_bits≠0.
  - After the last counted bit:
    - Full byte → PARITY. out_data = ~(XOR of the 8 data bits), i.e. odd parity.
    - Partial last byte → frame ends (see below).
- PARITY, on out_req:
  - If the byte was last → frame ends.
  - Else if buf_full → load the next byte, go to DATA.
  - Else → underrun pulse, frame aborted.
- Frame end / abort:
  - out_valid, out_last and out_data go to 0; FSM returns to IDLE.
  - A buffered byte then starts a new frame.
- out_last = 1 while presenting the final bit: the parity bit of a full last byte, or the final data bit of a partial last byte.
- out_req is ignored while out_valid = 0.
- A 0-byte frame cannot be sent. The minimum frame is SOC plus 1 bit.
- The buffer accepts the next byte while the current byte is shifting. Upstream must supply each byte before the parity bit of the preceding byte is consumed.

## Timing
- All outputs are registered.
- Reset values: out_valid = 0, out_data = 0, out_last = 0, underrun = 0, in_ready = 1. FSM = IDLE, buffer empty.
- Start latency: handshake in cycle N → out_valid = 1 with SOC in cycle N+1, provided the FSM was IDLE. in_ready returns to 1 in cycle N+2.
- out_req in cycle N → new out_data/out_last visible in cycle N+1. The downstream spacing between out_req pulses is arbitrary, with a minimum of 1 cycle.
- Simultaneous handshake and buffer-drain in the same cycle: both take effect and the buffer stays full. in_ready is computed from the registered buffer state, so this occurs only when in_ready was already high.
- Underrun: the pulse is asserted in the cycle after the offending out_req, coincident with out_valid falling.
- rst asserted mid-frame: all outputs return to reset values immediately (asynchronous). The buffered byte is discarded and no partial frame resumes.

## Structure
- ISO14443A_pkg:
  - odd-parity function, shared with frame_decode.
  - constant SOC_BIT = 1'b1.
- The FSM state enum is local to the module.
- Single module with no sub-module. The one-byte buffer is too small to justify a FIFO instance.

## Test plan
- 0x01, last, in_bits=0: bit sequence 1,1,0,0,0,0,0,0,0,0 (SOC, data, parity 0); out_last only on the 10th bit.
- 0x00, last: 1, eight 0s, parity 1.
- 0x05, last, in_bits=3: 1,1,0,1, no parity bit; out_last on the 4th bit. Repeat for in_bits 1–7.
- 3-byte frame 0xA5,0x3C,0xFF supplied back-to-back with random out_req spacing (1–20 cycles): 28 bits with parities 1,1,1; no underrun.
- 2-byte frame with the second byte withheld until after the first parity is consumed: underrun pulse; out_valid drops without out_last; the late byte starts a fresh frame with SOC.
- rst asserted mid-DATA: outputs zero immediately, in_ready = 1 after release, and the next frame encodes correctly.
